// File: rtl/per_stream_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | per_stream_pkg : register map, STATUS bit positions and bus encodings        |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
package per_stream_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_RXCOUNT = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_WIDTH    = 6;

  localparam logic W_R_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, head reads 0 while empty           |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_pop,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DATA_WIDTH-1:0]     o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop lands in the same cycle.
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_rst) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/per_stream_port.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | per_stream_port : peripheral-bus bridge to TX/RX valid-ready word streams   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module per_stream_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr_bus,
  input  logic                  i_cs_perif,
  input  logic                  i_w_r,
  inout  wire  [DATA_WIDTH-1:0] io_data_bus,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready
);

  import per_stream_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] off;
  logic [1:0]            reg_sel;
  logic                  hit, wr_acc, rd_acc;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]         tx_count, rx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  tx_push_req, rx_pop_req, tx_pop, rx_push;
  logic                  tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [ST_WIDTH-1:0]   status;
  logic [DATA_WIDTH-1:0] rdata;

  // Unsigned wrap makes addresses below BASE_ADDR decode as misses.
  assign off     = i_addr_bus - ADDR_WIDTH'(BASE_ADDR);
  assign hit     = i_cs_perif & (off < ADDR_WIDTH'(4));
  assign reg_sel = off[1:0];
  assign wr_acc  = hit & (i_w_r == W_R_WRITE);
  assign rd_acc  = hit & (i_w_r != W_R_WRITE);

  assign tx_push_req = wr_acc & (reg_sel == REG_TXDATA);
  assign rx_pop_req  = rd_acc & (reg_sel == REG_RXDATA);
  assign tx_pop      = ~tx_empty & i_tx_ready;
  assign o_rx_ready  = ~rx_full & ~i_rst;
  assign rx_push     = i_rx_valid & o_rx_ready;
  assign o_tx_valid  = ~tx_empty;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (tx_push_req),
    .i_wdata (io_data_bus),
    .i_pop   (tx_pop),
    .o_full  (tx_full),
    .o_empty (tx_empty),
    .o_count (tx_count),
    .o_head  (o_tx_data)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_push),
    .i_wdata (i_rx_data),
    .i_pop   (rx_pop_req),
    .o_full  (rx_full),
    .o_empty (rx_empty),
    .o_count (rx_count),
    .o_head  (rx_head)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_UDF]   = rx_udf_q;
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (wr_acc && (reg_sel == REG_STATUS)) begin
      tx_ovf_d = tx_ovf_q & ~io_data_bus[ST_TX_OVF];
      rx_udf_d = rx_udf_q & ~io_data_bus[ST_RX_UDF];
    end
    if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
    if (rx_pop_req && rx_empty) rx_udf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_TXDATA:  rdata = {{(DATA_WIDTH-CW){1'b0}}, tx_count};
      REG_RXDATA:  rdata = rx_head;
      REG_STATUS:  rdata = {{(DATA_WIDTH-ST_WIDTH){1'b0}}, status};
      REG_RXCOUNT: rdata = {{(DATA_WIDTH-CW){1'b0}}, rx_count};
      default:     rdata = '0;
    endcase
  end

  assign io_data_bus = rd_acc ? rdata : 'z;

endmodule
`default_nettype wire

// File: doc/per_stream_port.md
# per_stream_port

Memory-mapped peripheral responder for the BIP peripheral bus: it is the device side of the address/chip-select/write-read/data-bus interface driven by the CPU's data-memory decoder. It bridges CPU register accesses to two external valid/ready byte-word streams through a TX FIFO (CPU → stream) and an RX FIFO (stream → CPU), with sticky overflow/underflow status. One instance sits on the shared tri-state peripheral data bus at a configurable base address.

## Interface
- DATA_WIDTH, 16, bus and stream word width
- ADDR_WIDTH, 10, peripheral address bus width
- BASE_ADDR, 0, address of register 0; block decodes BASE_ADDR..BASE_ADDR+3
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2

- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_addr_bus  in  ADDR_WIDTH  peripheral address
- i_cs_perif  in  1  peripheral chip select, active high
- i_w_r  in  1  1 = write, 0 = read
- io_data_bus  inout  DATA_WIDTH  shared data bus
- o_tx_data  out  DATA_WIDTH  TX FIFO head word
- o_tx_valid  out  1  TX FIFO not empty
- i_tx_ready  in  1  sink accepts o_tx_data
- i_rx_data  in  DATA_WIDTH  incoming word
- i_rx_valid  in  1  i_rx_data valid
- o_rx_ready  out  1  RX FIFO can accept

## Operation
- Hit = i_cs_perif & (i_addr_bus − BASE_ADDR) < 4. No hit: io_data_bus = Z, no state change.
- Registers (offset): 0 TXDATA — W pushes TX FIFO, R returns TX occupancy; 1 RXDATA — R returns RX head and pops, W ignored; 2 STATUS — R returns {…0, rx_underflow[5], tx_overflow[4], rx_full[3], rx_empty[2], tx_full[1], tx_empty[0]}, W with bit set clears the corresponding sticky bit (bits 4,5 only); 3 RXCOUNT — R returns RX occupancy, W ignored.
- Reads: io_data_bus driven combinationally while hit & i_w_r=0; Z otherwise. Side effects (pop) commit at the rising edge ending the access cycle.
- Write to TXDATA when tx_full (evaluated at cycle start): word dropped, tx_overflow set. Pop by stream in the same cycle does not rescue it.
- Read of RXDATA when rx_empty: returns 0, no pop, rx_underflow set.
- TX stream: o_tx_valid = !tx_empty; o_tx_data = head (first-word-fall-through); pop on o_tx_valid & i_tx_ready.
- RX stream: o_rx_ready = !rx_full & !i_rst; push on i_rx_valid & o_rx_ready.
- CPU push and stream pop on TX in one cycle (not full): occupancy unchanged, order preserved. Same for RX stream push + CPU pop (not empty).
- Pointers wrap modulo FIFO_DEPTH; occupancy width clog2(FIFO_DEPTH)+1, zero-extended to DATA_WIDTH.

## Timing
- Reset (edge with i_rst=1): both FIFOs empty, sticky flags 0, o_tx_valid 0, o_rx_ready 0 while i_rst high, o_tx_data 0, io_data_bus Z.
- Reset mid-stream or mid-access wins over any push/pop in that cycle; FIFO contents discarded.
- CPU write at edge N → o_tx_valid high in cycle N+1; latency 1.
- RX push at edge N → RXDATA/RXCOUNT reflect it in cycle N+1.
- Read data valid same cycle as access (combinational from registered state); 0-cycle bus turnaround, no wait states.
- Status bits reflect state at cycle start; sticky set and clear in same cycle: set wins.

## Structure
- Shared package per_stream_pkg: register offsets (REG_TXDATA=0, REG_RXDATA=1, REG_STATUS=2, REG_RXCOUNT=3), STATUS bit positions, 1=write encoding of i_w_r.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice; top holds decode, bus tri-state, sticky flags.

## Test plan
- Reset, then read STATUS → 0x0005 (tx_empty, rx_empty); o_tx_valid=0, o_rx_ready=1 after i_rst drops.
- Write 0x1234, 0xBEEF to TXDATA with i_tx_ready=0 → TXDATA read returns 2; raise i_tx_ready → o_tx_data 0x1234 then 0xBEEF on consecutive cycles, o_tx_valid falls after.
- Write 9 words with i_tx_ready=0 (DEPTH 8) → 9th dropped, STATUS bit4 set; write STATUS 0x0010 → bit4 clears.
- Stream in 0xA001..0xA008 → o_rx_ready=0, RXCOUNT=8; read RXDATA 8 times → 0xA001..0xA008 in order; 9th read returns 0, STATUS bit5 set.
- Simultaneous CPU TXDATA write and stream pop at occupancy 3 → occupancy stays 3, output order preserved; access at BASE_ADDR+4 or i_cs_perif=0 → io_data_bus Z, no state change.
- Assert i_rst with both FIFOs half full mid-transfer → next cycle both empty, flags 0, no spurious o_tx_valid.
